// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch front end owning the PC and the IF/ID register.
//   i_clock, i_reset       : clock and synchronous active-high reset
//   i_stall                : hold PC and IF/ID (load-use hazard)
//   i_branch_taken/_target : redirect fetch from EX/MEM, flush IF/ID to NOP
//   o_imem_addr/i_imem_data: asynchronous instruction memory port
//   o_if_id_pc/_instr/_valid: IF/ID contents (PC+4, word, real-fetch flag)
//   o_halted, o_fetch_count: HALTED state flag and count of valid captures
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] NOP_WORD  = 32'h00000000,
    parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_data,
    output logic [31:0] o_if_id_pc,
    output logic [31:0] o_if_id_instr,
    output logic        o_if_id_valid,
    output logic        o_halted,
    output logic [15:0] o_fetch_count
);
    typedef enum logic {RUN, HALTED} state_t;

    state_t      r_state, w_state_n;
    logic [31:0] r_pc, w_pc_n, r_instr, w_instr_n, r_if_pc, w_if_pc_n;
    logic        r_valid, w_valid_n;
    logic [15:0] r_cnt, w_cnt_n;
    logic [31:0] w_pc4;

    assign w_pc4 = r_pc + 32'd4;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
            r_instr <= NOP_WORD;
            r_if_pc <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_pc    <= w_pc_n;
            r_instr <= w_instr_n;
            r_if_pc <= w_if_pc_n;
            r_valid <= w_valid_n;
            r_cnt   <= w_cnt_n;
        end
    end

    // Priority: branch > stall > halted hold > run advance.
    always_comb begin
        w_state_n = r_state;
        w_pc_n    = r_pc;
        w_instr_n = r_instr;
        w_if_pc_n = r_if_pc;
        w_valid_n = r_valid;
        w_cnt_n   = r_cnt;
        if (i_branch_taken) begin
            w_state_n = RUN;
            w_pc_n    = {i_branch_target[31:2], 2'b00};
            w_instr_n = NOP_WORD;
            w_if_pc_n = '0;
            w_valid_n = 1'b0;
        end else if (!i_stall) begin
            if (r_state == HALTED) begin
                w_instr_n = NOP_WORD;
                w_if_pc_n = '0;
                w_valid_n = 1'b0;
            end else begin
                // The HALT word itself is a real fetch: captured and counted, but PC stops.
                w_instr_n = i_imem_data;
                w_if_pc_n = w_pc4;
                w_valid_n = 1'b1;
                w_cnt_n   = r_cnt + 16'd1;
                w_state_n = (i_imem_data == HALT_WORD) ? HALTED : RUN;
                w_pc_n    = (i_imem_data == HALT_WORD) ? r_pc : w_pc4;
            end
        end
    end

    assign o_imem_addr   = r_pc;
    assign o_if_id_pc    = r_if_pc;
    assign o_if_id_instr = r_instr;
    assign o_if_id_valid = r_valid;
    assign o_halted      = (r_state == HALTED);
    assign o_fetch_count = r_cnt;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage.
module tb_fetch_stage;
    logic        clock = 1'b0;
    logic        reset, stall, branch_taken;
    logic [31:0] branch_target, imem_addr, imem_data, if_id_pc, if_id_instr;
    logic        if_id_valid, halted;
    logic [15:0] fetch_count;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    fetch_stage dut (
        .i_clock        (clock),
        .i_reset        (reset),
        .i_stall        (stall),
        .i_branch_taken (branch_taken),
        .i_branch_target(branch_target),
        .o_imem_addr    (imem_addr),
        .i_imem_data    (imem_data),
        .o_if_id_pc     (if_id_pc),
        .o_if_id_instr  (if_id_instr),
        .o_if_id_valid  (if_id_valid),
        .o_halted       (halted),
        .o_fetch_count  (fetch_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, push the IF/ID expectation, then pop and compare after the edge.
    task automatic cyc(input string tag, input logic r, input logic s, input logic b,
                       input logic [31:0] t, input logic [31:0] d,
                       input logic [31:0] ei, input logic [31:0] ep, input logic ev,
                       input logic [31:0] ea, input logic eh, input logic [15:0] ec);
        exp_t e;
        reset = r; stall = s; branch_taken = b; branch_target = t; imem_data = d;
        sb.push_back('{ei, ep, ev});
        @(posedge clock);
        #1;
        e = sb.pop_front();
        chk({tag, ".instr"}, if_id_instr, e.instr);
        chk({tag, ".pc"}, if_id_pc, e.pc);
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e.valid});
        chk({tag, ".addr"}, imem_addr, ea);
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, eh});
        chk({tag, ".count"}, {16'd0, fetch_count}, {16'd0, ec});
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; imem_data = '0;
        #1;
        //  tag        rst st br target        imem_data     instr         if_pc         v  addr          h  count
        cyc("reset",   1, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        0, 16'd0);
        cyc("run1",    0, 0, 0, 32'h0,        32'h20080005, 32'h20080005, 32'h4,        1, 32'h4,        0, 16'd1);
        cyc("run2",    0, 0, 0, 32'h0,        32'h20090003, 32'h20090003, 32'h8,        1, 32'h8,        0, 16'd2);
        cyc("stall1",  0, 1, 0, 32'h0,        32'h01095020, 32'h20090003, 32'h8,        1, 32'h8,        0, 16'd2);
        cyc("stall2",  0, 1, 0, 32'h0,        32'h01095020, 32'h20090003, 32'h8,        1, 32'h8,        0, 16'd2);
        cyc("resume",  0, 0, 0, 32'h0,        32'h01095020, 32'h01095020, 32'hC,        1, 32'hC,        0, 16'd3);
        cyc("br_stl",  0, 1, 1, 32'h43,       32'h12345678, 32'h0,        32'h0,        0, 32'h40,       0, 16'd3);
        cyc("br_wrap", 0, 0, 1, 32'hFFFFFFFF, 32'h12345678, 32'h0,        32'h0,        0, 32'hFFFFFFFC, 0, 16'd3);
        cyc("wrap",    0, 0, 0, 32'h0,        32'h00000001, 32'h00000001, 32'h0,        1, 32'h0,        0, 16'd4);
        cyc("br_10",   0, 0, 1, 32'h10,       32'h0,        32'h0,        32'h0,        0, 32'h10,       0, 16'd4);
        cyc("halt",    0, 0, 0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'h14,       1, 32'h10,       1, 16'd5);
        cyc("hold1",   0, 0, 0, 32'h0,        32'h8C010000, 32'h0,        32'h0,        0, 32'h10,       1, 16'd5);
        cyc("hold2",   0, 0, 0, 32'h0,        32'hFFFFFFFF, 32'h0,        32'h0,        0, 32'h10,       1, 16'd5);
        cyc("hstall",  0, 1, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h10,       1, 16'd5);
        cyc("rst_hlt", 1, 1, 1, 32'h80,       32'h0,        32'h0,        32'h0,        0, 32'h0,        0, 16'd0);
        cyc("halt0",   0, 0, 0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'h4,        1, 32'h0,        1, 16'd1);
        cyc("br_out",  0, 0, 1, 32'h20,       32'h0,        32'h0,        32'h0,        0, 32'h20,       0, 16'd1);
        cyc("run20",   0, 0, 0, 32'h0,        32'hAC020004, 32'hAC020004, 32'h24,       1, 32'h24,       0, 16'd2);
        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the 5-stage MIPS pipeline. Owns the PC register and the IF/ID pipeline register.
- Drives the instruction memory address each cycle and captures the returned word plus PC+4 into IF/ID for the decode stage.
- Handles load-use stall (hold), branch redirect from EX/MEM (flush to NOP) and a HALT state.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_WORD, 32'h00000000, instruction injected into IF/ID on flush or while halted.
- HALT_WORD, 32'hFFFFFFFF, fetched word that stops fetching.

Ports:
- clock  input  1  single system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- stall  input  1  from hazard unit; hold PC and IF/ID.
- branch_taken  input  1  EX/MEM zero AND branch; redirect fetch.
- branch_target  input  32  EX/MEM branch address.
- imem_addr  output  32  equals current PC; combinational from PC register.
- imem_data  input  32  instruction memory read data for imem_addr, same cycle (asynchronous read).
- if_id_pc  output  32  PC+4 of the instruction held in IF/ID.
- if_id_instr  output  32  instruction held in IF/ID.
- if_id_valid  output  1  1 when if_id_instr is a real fetched word, 0 for injected NOP.
- halted  output  1  1 while in HALTED state.
- fetch_count  output  16  number of words captured into IF/ID with valid=1.

Behaviour:
- Reset (sync, evaluated at posedge, highest priority):
  - PC=RESET_PC, if_id_instr=NOP_WORD, if_id_pc=0, if_id_valid=0, halted=0, fetch_count=0, state=RUN.
- States: RUN, HALTED. Per-posedge priority, first match wins: reset > branch_taken > stall > HALTED hold > RUN advance.
- branch_taken=1 (either state):
  - PC <= {branch_target[31:2],2'b00}; low two bits forced to zero.
  - IF/ID <= NOP_WORD, if_id_pc=0, valid=0.
  - state <= RUN, halted <= 0. Branch overrides a simultaneous stall.
- stall=1, no branch: PC, IF/ID, valid, state and fetch_count all hold.
- HALTED, no branch/stall: PC holds. IF/ID <= NOP_WORD with valid=0.
- RUN advance:
  - if_id_instr <= imem_data, if_id_pc <= PC+4, valid <= 1, fetch_count <= fetch_count+1.
  - If imem_data==HALT_WORD: the HALT word is still captured with valid=1 and counted. PC holds, state <= HALTED, halted=1 from the next cycle.
  - Otherwise PC <= PC+4.
- Arithmetic wraps, no saturation or flagging:
  - PC+4 is mod 2^32, so 32'hFFFFFFFC -> 32'h00000000.
  - fetch_count is mod 2^16, so 16'hFFFF -> 0.
- Latency: imem_data presented at cycle N appears on if_id_instr after posedge N+1 (one cycle).
- Reset asserted mid-stall, mid-halt or during a branch: reset wins, all state as listed under reset.
- No X propagation: every register has a defined reset value. Outputs are registered except imem_addr.

Test Plan:
- Reset then 3 free-running cycles with imem returning 0x20080005, 0x20090003, 0x01095020 -> imem_addr 0,4,8,12. if_id_instr follows one cycle behind with if_id_pc 4,8,12, valid=1, fetch_count=3.
- stall=1 for 2 cycles after PC=8 -> PC stays 8, IF/ID holds 0x20090003/pc 8, fetch_count unchanged. Release -> resumes at 8.
- branch_taken=1, branch_target=0x00000043, stall=1 same cycle -> PC=0x40, if_id_instr=0, valid=0. Next cycle fetches from 0x40.
- imem returns 0xFFFFFFFF at PC=0x10 -> IF/ID gets 0xFFFFFFFF valid=1, halted=1, PC stays 0x10. Following cycles IF/ID=NOP valid=0, fetch_count frozen. branch_taken to 0x20 -> halted=0, PC=0x20.
- Force PC to 0xFFFFFFFC via branch, then advance one cycle -> PC=0x00000000, if_id_pc=0x00000000.
- Assert reset while halted with fetch_count=5 -> next posedge PC=RESET_PC, halted=0, fetch_count=0, valid=0.
